// File: rtl/input_mem_ctrl.sv
// -----------------------------------------------------------------------------
// input_mem_ctrl
//
// Address sequencer for a 64-byte pixel buffer that holds one 4x4 tile of
// 24-bit B/G/R pixels (pixel s lives at bytes 3s, 3s+1 and 3s+2). A pass loads
// twelve 32-bit words into bytes 0..47. It then reads the tile back, one pixel
// per cycle, in rotated order (0, 90 CW, 180 or 270 CW degrees).
//
// The buffer writes all four byte lanes on every clock edge. Any cycle without
// an accepted word therefore steers those writes to a scratch area at
// PARK_BASE..PARK_BASE+3.
//
// Ports
//   I_HCLK                    clock, rising edge
//   I_HRESET                  synchronous active-high reset
//   I_START                   start one load+rotate pass (sampled in IDLE only)
//   I_MODE[1:0]               rotation select, latched on an accepted start
//   I_WVALID                  write word on the bus is valid
//   O_WREADY                  controller accepts a write word this cycle
//   O_PIXEL_IN_ADDR0..3[7:0]  byte write addresses for the four byte lanes
//   O_PIXEL_OUT_ADDRB/G/R     byte read addresses for one pixel
//   O_PIXEL_VALID             buffer read outputs hold a rotated pixel
//   O_PIXEL_IDX[3:0]          output-order index of that pixel
//   O_BUSY                    FSM is in LOAD or READ
//   O_DONE                    single-cycle end-of-pass pulse
// -----------------------------------------------------------------------------
module input_mem_ctrl #(
    parameter logic [7:0] PARK_BASE = 8'd60
) (
    input  logic       I_HCLK,
    input  logic       I_HRESET,
    input  logic       I_START,
    input  logic [1:0] I_MODE,
    input  logic       I_WVALID,
    output logic       O_WREADY,
    output logic [7:0] O_PIXEL_IN_ADDR0,
    output logic [7:0] O_PIXEL_IN_ADDR1,
    output logic [7:0] O_PIXEL_IN_ADDR2,
    output logic [7:0] O_PIXEL_IN_ADDR3,
    output logic [7:0] O_PIXEL_OUT_ADDRB,
    output logic [7:0] O_PIXEL_OUT_ADDRG,
    output logic [7:0] O_PIXEL_OUT_ADDRR,
    output logic       O_PIXEL_VALID,
    output logic [3:0] O_PIXEL_IDX,
    output logic       O_BUSY,
    output logic       O_DONE
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRead,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] k_q, k_d;          // word counter during LOAD
    logic [3:0] p_q, p_d;          // output pixel counter during READ
    logic [1:0] mode_q, mode_d;
    logic       valid_q, valid_d;
    logic [3:0] idx_q, idx_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        mode_d  = mode_q;

        unique case (state_q)
            StIdle: begin
                if (I_START) begin
                    state_d = StLoad;
                    k_d     = 4'd0;
                    mode_d  = I_MODE;
                end
            end
            StLoad: begin
                if (I_WVALID) begin
                    k_d = k_q + 4'd1;
                    if (k_q == 4'd11) begin
                        state_d = StRead;
                        p_d     = 4'd0;
                    end
                end
            end
            StRead: begin
                // p wraps back to 0 after 15, ready for the next pass
                p_d = p_q + 4'd1;
                if (p_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The buffer returns read data one edge after the address is presented
        valid_d = (state_q == StRead);
        idx_d   = p_q;
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q <= StIdle;
            k_q     <= 4'd0;
            p_q     <= 4'd0;
            mode_q  <= 2'd0;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Rotation: map output (r,c) to source (sr,sc). 3-x on 2 bits is ~x.
    // ------------------------------------------------------------------
    logic [1:0] row, col;
    logic [1:0] src_row, src_col;
    logic [3:0] src_pix;
    logic [7:0] src_byte;

    always_comb begin
        row = p_q[3:2];
        col = p_q[1:0];
        unique case (mode_q)
            2'd0: begin src_row = row;  src_col = col;  end
            2'd1: begin src_row = ~col; src_col = row;  end
            2'd2: begin src_row = ~row; src_col = ~col; end
            2'd3: begin src_row = col;  src_col = ~row; end
            default: begin src_row = row; src_col = col; end
        endcase
        src_pix  = {src_row, src_col};
        // 3*s as s + 2s, kept in 8 bits
        src_byte = {4'd0, src_pix} + {3'd0, src_pix, 1'b0};
    end

    // ------------------------------------------------------------------
    // Outputs. Reset overrides the state-decoded outputs, because state_q
    // may still hold LOAD/READ during the cycle in which reset is asserted.
    // ------------------------------------------------------------------
    logic in_load, in_read, wr_accept;

    always_comb begin
        in_load   = (state_q == StLoad) && !I_HRESET;
        in_read   = (state_q == StRead) && !I_HRESET;
        wr_accept = in_load && I_WVALID;

        O_WREADY = in_load;
        O_BUSY   = in_load || in_read;
        O_DONE   = (state_q == StDone);

        if (wr_accept) begin
            O_PIXEL_IN_ADDR0 = {2'b00, k_q, 2'd0};
            O_PIXEL_IN_ADDR1 = {2'b00, k_q, 2'd1};
            O_PIXEL_IN_ADDR2 = {2'b00, k_q, 2'd2};
            O_PIXEL_IN_ADDR3 = {2'b00, k_q, 2'd3};
        end else begin
            O_PIXEL_IN_ADDR0 = PARK_BASE;
            O_PIXEL_IN_ADDR1 = PARK_BASE + 8'd1;
            O_PIXEL_IN_ADDR2 = PARK_BASE + 8'd2;
            O_PIXEL_IN_ADDR3 = PARK_BASE + 8'd3;
        end

        if (in_read) begin
            O_PIXEL_OUT_ADDRB = src_byte;
            O_PIXEL_OUT_ADDRG = src_byte + 8'd1;
            O_PIXEL_OUT_ADDRR = src_byte + 8'd2;
        end else begin
            O_PIXEL_OUT_ADDRB = PARK_BASE + 8'd3;
            O_PIXEL_OUT_ADDRG = PARK_BASE + 8'd3;
            O_PIXEL_OUT_ADDRR = PARK_BASE + 8'd3;
        end
    end

    assign O_PIXEL_VALID = valid_q;
    assign O_PIXEL_IDX   = idx_q;

endmodule

// File: tb/tb_input_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for input_mem_ctrl. It includes a behavioural 64-byte buffer with
// unconditional writes and registered reads. Expected pixels come from
// rotating a 4x4 index grid clockwise by 90 degrees, I_MODE times.
// -----------------------------------------------------------------------------
module tb_input_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode_i;
    logic       wvalid;
    logic [31:0] wdata;
    logic       wready;
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] ab, ag, ar;
    logic       pvalid;
    logic [3:0] pidx;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    input_mem_ctrl #(.PARK_BASE(8'd60)) dut (
        .I_HCLK           (clk),
        .I_HRESET         (rst),
        .I_START          (start),
        .I_MODE           (mode_i),
        .I_WVALID         (wvalid),
        .O_WREADY         (wready),
        .O_PIXEL_IN_ADDR0 (a0),
        .O_PIXEL_IN_ADDR1 (a1),
        .O_PIXEL_IN_ADDR2 (a2),
        .O_PIXEL_IN_ADDR3 (a3),
        .O_PIXEL_OUT_ADDRB(ab),
        .O_PIXEL_OUT_ADDRG(ag),
        .O_PIXEL_OUT_ADDRR(ar),
        .O_PIXEL_VALID    (pvalid),
        .O_PIXEL_IDX      (pidx),
        .O_BUSY           (busy),
        .O_DONE           (done)
    );

    // Buffer model: four byte writes every edge, registered B/G/R reads.
    logic [7:0] mem [64];
    logic [7:0] rd_b, rd_g, rd_r;
    always @(posedge clk) begin
        mem[a0[5:0]] <= wdata[7:0];
        mem[a1[5:0]] <= wdata[15:8];
        mem[a2[5:0]] <= wdata[23:16];
        mem[a3[5:0]] <= wdata[31:24];
        rd_b <= mem[ab[5:0]];
        rd_g <= mem[ag[5:0]];
        rd_r <= mem[ar[5:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode_i = 2'd1; wvalid = 1'b1; wdata = 32'h0;
        repeat (3) begin
            @(negedge clk); #1;
            tests_run++;
            if ({wready, busy, done, pvalid, pidx} !== 8'h00) begin
                fails++;
                $display("FAIL reset_outputs: got wready/busy/done/valid/idx=%b want 00000000",
                         {wready, busy, done, pvalid, pidx});
            end
            tests_run++;
            if ({a0, a1, a2, a3, ab, ag, ar} !== {8'd60, 8'd61, 8'd62, 8'd63, 8'd63, 8'd63, 8'd63}) begin
                fails++;
                $display("FAIL reset_addrs: got %0d %0d %0d %0d / %0d %0d %0d want 60 61 62 63 / 63 63 63",
                         a0, a1, a2, a3, ab, ag, ar);
            end
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; wvalid = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_after_release: got busy=%b want 0", busy);
        end
    endtask

    // One complete pass. gap_max>0 inserts idle LOAD cycles; start_p>=0 pulses a
    // spurious start (mode 2) at that READ pixel; rst_p>=0 resets at that pixel.
    task automatic run_pass(input logic [1:0] mode, input int gap_max, input int start_p,
                            input int rst_p);
        logic [31:0] words [12];
        logic [7:0]  lb    [48];
        int          rot   [16];
        int          tmp   [16];
        int          g;
        for (int i = 0; i < 12; i++) begin
            words[i] = $urandom;
            for (int n = 0; n < 4; n++) lb[4*i+n] = words[i][8*n +: 8];
        end
        for (int i = 0; i < 16; i++) rot[i] = i;
        for (int m = 0; m < int'(mode); m++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[4*r+c] = rot[4*(3-c)+r];
            rot = tmp;
        end

        @(negedge clk);
        start = 1'b1; mode_i = mode; wvalid = 1'b0; #1;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_before_start: got busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0; mode_i = ~mode;

        for (int i = 0; i < 12; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (gap_max > 0 && (i == 1 || i == 2)) g = (i == 1) ? 2 : 0;
            for (int j = 0; j < g; j++) begin
                wvalid = 1'b0; wdata = $urandom; #1;
                tests_run++;
                if ({wready, a0, a1, a2, a3} !== {1'b1, 8'd60, 8'd61, 8'd62, 8'd63}) begin
                    fails++;
                    $display("FAIL load_gap word%0d: got wready=%b addr %0d %0d %0d %0d want 1 60 61 62 63",
                             i, wready, a0, a1, a2, a3);
                end
                @(negedge clk);
            end
            wvalid = 1'b1; wdata = words[i]; #1;
            tests_run++;
            if ({wready, a0, a1, a2, a3} !== {1'b1, 8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}) begin
                fails++;
                $display("FAIL load_word%0d: got wready=%b addr %0d %0d %0d %0d want 1 %0d %0d %0d %0d",
                         i, wready, a0, a1, a2, a3, 4*i, 4*i+1, 4*i+2, 4*i+3);
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wdata = $urandom;

        for (int p = 0; p < 16; p++) begin
            start  = (p == start_p);
            mode_i = (p == start_p) ? 2'd2 : mode;
            if (p == rst_p) begin
                rst = 1'b1; #1;
                tests_run++;
                if ({wready, busy, a0, a3, ab, ag, ar} !==
                    {1'b0, 1'b0, 8'd60, 8'd63, 8'd63, 8'd63, 8'd63}) begin
                    fails++;
                    $display("FAIL in_reset_outputs: got wready=%b busy=%b a0=%0d a3=%0d b/g/r=%0d/%0d/%0d want 0 0 60 63 63/63/63",
                             wready, busy, a0, a3, ab, ag, ar);
                end
                @(negedge clk);
                rst = 1'b0; start = 1'b0; #1;
                tests_run++;
                if ({busy, pvalid, done} !== 3'b000) begin
                    fails++;
                    $display("FAIL after_reset_idle: got busy/valid/done=%b want 000",
                             {busy, pvalid, done});
                end
                for (int j = 0; j < 18; j++) begin
                    @(negedge clk); #1;
                    tests_run++;
                    if ({busy, pvalid, done} !== 3'b000) begin
                        fails++;
                        $display("FAIL no_done_after_reset cyc%0d: got busy/valid/done=%b want 000",
                                 j, {busy, pvalid, done});
                    end
                end
                return;
            end
            #1;
            tests_run++;
            if ({busy, wready, ab, ag, ar} !==
                {1'b1, 1'b0, 8'(3*rot[p]), 8'(3*rot[p]+1), 8'(3*rot[p]+2)}) begin
                fails++;
                $display("FAIL read_addr mode%0d p%0d: got busy=%b wready=%b b/g/r=%0d/%0d/%0d want 1 0 %0d/%0d/%0d",
                         mode, p, busy, wready, ab, ag, ar, 3*rot[p], 3*rot[p]+1, 3*rot[p]+2);
            end
            tests_run++;
            if (pvalid !== (p > 0)) begin
                fails++;
                $display("FAIL read_valid p%0d: got %b want %b", p, pvalid, (p > 0));
            end
            if (p > 0) begin
                tests_run++;
                if ({pidx, rd_b, rd_g, rd_r} !==
                    {4'(p-1), lb[3*rot[p-1]], lb[3*rot[p-1]+1], lb[3*rot[p-1]+2]}) begin
                    fails++;
                    $display("FAIL pixel mode%0d idx%0d: got idx=%0d bgr=%h%h%h want idx=%0d bgr=%h%h%h",
                             mode, p-1, pidx, rd_b, rd_g, rd_r, p-1,
                             lb[3*rot[p-1]], lb[3*rot[p-1]+1], lb[3*rot[p-1]+2]);
                end
            end
            @(negedge clk);
        end
        start = 1'b0; mode_i = mode; #1;
        tests_run++;
        if ({done, busy, pvalid, pidx, ab} !== {1'b1, 1'b0, 1'b1, 4'd15, 8'd63}) begin
            fails++;
            $display("FAIL done_cycle: got done=%b busy=%b valid=%b idx=%0d addrb=%0d want 1 0 1 15 63",
                     done, busy, pvalid, pidx, ab);
        end
        tests_run++;
        if ({rd_b, rd_g, rd_r} !== {lb[3*rot[15]], lb[3*rot[15]+1], lb[3*rot[15]+2]}) begin
            fails++;
            $display("FAIL last_pixel mode%0d: got bgr=%h%h%h want %h%h%h", mode, rd_b, rd_g, rd_r,
                     lb[3*rot[15]], lb[3*rot[15]+1], lb[3*rot[15]+2]);
        end
        @(negedge clk); #1;
        tests_run++;
        if ({done, busy, pvalid} !== 3'b000) begin
            fails++;
            $display("FAIL after_done: got done/busy/valid=%b want 000", {done, busy, pvalid});
        end
    endtask

    task automatic test_mode0();
        run_pass(2'd0, 0, -1, -1);
    endtask

    task automatic test_modes();
        run_pass(2'd1, 0, -1, -1);
        run_pass(2'd2, 0, -1, -1);
        run_pass(2'd3, 0, -1, -1);
    endtask

    task automatic test_wvalid_gaps();
        run_pass(2'($urandom_range(0, 3)), 2, -1, -1);
    endtask

    task automatic test_start_ignored();
        run_pass(2'd0, 0, 5, -1);
    endtask

    task automatic test_reset_mid_read();
        run_pass(2'd0, 0, -1, 7);
        run_pass(2'd1, 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_pass(2'($urandom_range(0, 3)), 0, -1, -1);
        run_pass(2'($urandom_range(0, 3)), 1, -1, -1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode_i = 2'd0; wvalid = 1'b0; wdata = 32'h0;
        test_reset();
        test_mode0();
        test_modes();
        test_wvalid_gaps();
        test_start_ignored();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
